char_row_writer: RTL and testbench
==================================

CHAR_ROW_WRITER -- requirements
Module: char_row_writer

Interface
REQ-001 Parameter NUM_COLS, default 15, number of writable character columns (valid addresses 0..NUM_COLS-1).
REQ-002 Parameter FIFO_DEPTH, default 4, number of pending write entries (power of two).
REQ-003 clk  input  1  system clock (pixel clock domain); the block has one clock.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 sclk  input  1  serial clock from microcontroller, asynchronous to clk.
REQ-006 sdata  input  1  serial data, sampled on sclk rising edge, MSB first.
REQ-007 scs_n  input  1  serial frame select, active-low.
REQ-008 blank  input  1  display blanking indicator; writes permitted only while high.
REQ-009 char_in  output  6  character code presented to the row buffer.
REQ-010 address  output  4  column address presented to the row buffer.
REQ-011 write  output  1  single-cycle write strobe to the row buffer.
REQ-012 pending  output  1  high while FIFO not empty.
REQ-013 overflow  output  1  sticky: a frame was dropped because the FIFO was full.
REQ-014 addr_err  output  1  sticky: a frame was dropped because address >= NUM_COLS.

Function
REQ-015 sclk, sdata, scs_n SHALL each pass through a 2-flop synchronizer; sclk rising edge detected from synchronized history (one clk pulse per edge).
REQ-016 Receiver FSM states: IDLE, SHIFT, HOLD.
REQ-017 IDLE -> SHIFT on synchronized scs_n low; bit counter cleared to 0.
REQ-018 In SHIFT, each sclk rising edge shifts sdata into a 10-bit register and increments the counter.
REQ-019 Frame format: bits 9..6 = column address, bits 5..0 = character code.
REQ-020 On the 10th bit, SHIFT -> HOLD and the frame is pushed to the FIFO in the cycle after that edge, if accepted.
REQ-021 HOLD ignores further sclk edges; HOLD -> IDLE on synchronized scs_n high.
REQ-022 scs_n high in SHIFT with counter < 10 SHALL abort the frame (no push, no flag) and return to IDLE.
REQ-023 Frame with address >= NUM_COLS SHALL not be pushed; addr_err sets.
REQ-024 Frame arriving with FIFO full SHALL be dropped; overflow sets; FIFO contents unchanged.
REQ-025 Drain: when blank high and FIFO not empty, pop one entry per cycle; write high for exactly that cycle with address/char_in carrying the popped entry.
REQ-026 When blank low, write SHALL stay low; entries remain queued.
REQ-027 Simultaneous push and pop in one cycle SHALL both succeed, including at full (pop frees the slot first) and at empty (entry not bypassed; written no earlier than the next cycle).
REQ-028 address and char_in SHALL hold their last written value when write is low.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
REQ-030 Latency: 10th sclk edge at synchronizer input to write high is 4 clk cycles minimum (2 sync, 1 edge detect/push, 1 pop), given blank high.

Reset
REQ-031 rst_n low SHALL asynchronously force: FSM IDLE, counter 0, shift register 0, FIFO empty, write 0, address 0, char_in 0, pending 0, overflow 0, addr_err 0, synchronizers to idle levels (sclk 0, sdata 0, scs_n 1).
REQ-032 Reset mid-frame or mid-drain discards all partial and queued frames; no write issued after rst_n asserts.
REQ-033 Sticky flags clear only on reset.

Structure
REQ-034 Frame width (10), field positions, address width (4) and char width (6) SHALL be constants in the shared package also used by the row buffer.
REQ-035 The FIFO SHALL be a sub-module named char_write_fifo (push, pop, full, empty, data); synchronizers and FSM stay in the top.

Verification
REQ-036 blank=1, frame addr=3 char=0x2A -> one write pulse, address=3, char_in=0x2A, 4 cycles after last edge.
REQ-037 blank=0, send 4 frames (addr 0..3, char 0x10..0x13), then 5th -> overflow=1, no writes; raise blank -> 4 consecutive writes in order 0..3, pending falls after the 4th.
REQ-038 Frame addr=15 -> no push, addr_err=1, pending=0.
REQ-039 scs_n raised after 6 bits, then valid frame addr=1 char=0x05 -> only that frame written; no flags.
REQ-040 FIFO full with blank=1 and new frame completing in the same cycle as a pop -> no overflow; all 5 entries written in order.
REQ-041 rst_n low during a drain with 3 entries queued -> write low immediately, all outputs at reset values, no writes after release until new frames.

Source files
------------

// File: rtl/char_row_writer_pkg.sv
// Shared constants and types for the character row path: serial frame layout,
// row-buffer field widths and the receiver state encoding.
package char_row_writer_pkg;

  // Serial frame layout: column address in the upper bits, character code below
  localparam int FRAME_W   = 10;
  localparam int ADDR_W    = 4;
  localparam int CHAR_W    = 6;
  localparam int ADDR_MSB  = 9;
  localparam int ADDR_LSB  = 6;
  localparam int CHAR_MSB  = 5;
  localparam int CHAR_LSB  = 0;
  localparam int BIT_CNT_W = 4;
  localparam int ENTRY_W   = ADDR_W + CHAR_W;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_HOLD
  } rx_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CHAR_W-1:0] code;
  } char_entry_t;

  // Split a received serial frame into its row-buffer fields
  function automatic char_entry_t frame_to_entry(input logic [FRAME_W-1:0] frame);
    char_entry_t e;
    e.addr = frame[ADDR_MSB:ADDR_LSB];
    e.code = frame[CHAR_MSB:CHAR_LSB];
    return e;
  endfunction

endpackage

// File: rtl/char_row_writer_fifo.sv
// Small synchronous FIFO holding pending row-buffer writes. A pop in the same
// cycle frees its slot for a simultaneous push, so a full FIFO still accepts a
// push when it is also being drained. Data is read from the head combinationally.
module char_write_fifo
  import char_row_writer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;
  logic             do_push;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/char_row_writer.sv
// Receives 10-bit serial frames from the microcontroller, queues them and
// writes them into the character row buffer only while the display is blanked.
module char_row_writer
  import char_row_writer_pkg::*;
#(
  parameter int NUM_COLS   = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              sdata,
  input  logic              scs_n,
  input  logic              blank,
  output logic [CHAR_W-1:0] char_in,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic              pending,
  output logic              overflow,
  output logic              addr_err
);

  logic [1:0]           sclk_sync_q;
  logic [1:0]           sdata_sync_q;
  logic [1:0]           scs_sync_q;
  logic                 sclk_prev_q;
  logic                 sclk_rise;

  rx_state_e            state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic                 overflow_q, overflow_d;
  logic                 addr_err_q, addr_err_d;
  logic [FRAME_W-1:0]   frame_next;
  char_entry_t          frame_entry;
  logic                 addr_ok;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  char_entry_t          fifo_head;

  logic                 write_q;
  logic [ADDR_W-1:0]    address_q;
  logic [CHAR_W-1:0]    char_q;

  // Bring the serial pins into the pixel clock domain; idle levels after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q  <= 2'b00;
      sdata_sync_q <= 2'b00;
      scs_sync_q   <= 2'b11;
      sclk_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[0], sclk};
      sdata_sync_q <= {sdata_sync_q[0], sdata};
      scs_sync_q   <= {scs_sync_q[0], scs_n};
      sclk_prev_q  <= sclk_sync_q[1];
    end
  end

  assign sclk_rise   = sclk_sync_q[1] && !sclk_prev_q;
  assign frame_next  = (shift_q << 1) | {{(FRAME_W-1){1'b0}}, sdata_sync_q[1]};
  assign frame_entry = frame_to_entry(frame_next);
  assign addr_ok     = (int'(frame_entry.addr) < NUM_COLS);
  assign fifo_pop    = blank && !fifo_empty;

  // Receiver state register and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Frame assembly; the completed frame is pushed on the edge that takes the
  // last bit, and a simultaneous pop makes room in a full FIFO
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    overflow_d = overflow_q;
    addr_err_d = addr_err_q;
    fifo_push  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!scs_sync_q[1]) begin
          state_d   = RX_SHIFT;
          bit_cnt_d = '0;
        end
      end
      RX_SHIFT: begin
        if (scs_sync_q[1]) begin
          state_d = RX_IDLE;
        end else if (sclk_rise) begin
          shift_d   = frame_next;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_CNT_W'(FRAME_W - 1)) begin
            state_d = RX_HOLD;
            if (!addr_ok) begin
              addr_err_d = 1'b1;
            end else if (fifo_full && !fifo_pop) begin
              overflow_d = 1'b1;
            end else begin
              fifo_push = 1'b1;
            end
          end
        end
      end
      RX_HOLD: begin
        if (scs_sync_q[1]) begin
          state_d = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  char_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (frame_entry),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Drain one entry per blanked cycle; address and code hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q   <= 1'b0;
      address_q <= '0;
      char_q    <= '0;
    end else begin
      write_q <= fifo_pop;
      if (fifo_pop) begin
        address_q <= fifo_head.addr;
        char_q    <= fifo_head.code;
      end
    end
  end

  assign write    = write_q;
  assign address  = address_q;
  assign char_in  = char_q;
  assign pending  = !fifo_empty;
  assign overflow = overflow_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_char_row_writer.sv
// Bench for char_row_writer: directed serial frames, a queue-based model of
// pending writes checked every cycle, and literal expectations per scenario.
module tb_char_row_writer;
  import char_row_writer_pkg::*;

  localparam int NUM_COLS   = 15;
  localparam int FIFO_DEPTH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       sclk  = 1'b0;
  logic       sdata = 1'b0;
  logic       scs_n = 1'b1;
  logic       blank = 1'b0;
  logic [5:0] char_in;
  logic [3:0] address;
  logic       write;
  logic       pending;
  logic       overflow;
  logic       addr_err;

  char_row_writer #(
    .NUM_COLS   (NUM_COLS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .sdata    (sdata),
    .scs_n    (scs_n),
    .blank    (blank),
    .char_in  (char_in),
    .address  (address),
    .write    (write),
    .pending  (pending),
    .overflow (overflow),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int code;
    int cyc;
  } entry_t;

  int     errCount   = 0;
  int     checkCount = 0;
  int     cycleCount = 0;

  entry_t modelQ[$];
  entry_t writeLog[$];
  entry_t popped;
  entry_t seen;
  int     frameTimer = 0;
  int     frameAddr  = 0;
  int     frameCode  = 0;
  bit     expWrite   = 1'b0;
  int     expAddr    = 0;
  int     expCode    = 0;
  bit     expOverflow = 1'b0;
  bit     expAddrErr  = 1'b0;

  bit     latencyArmed = 1'b0;
  int     lastRiseCyc  = 0;
  int     latency      = -1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cycleCount++;
  end

  // Model: a completed frame joins the queue three clocks after its last sclk
  // rise is driven; each blanked clock removes the oldest entry and that entry
  // must appear on the outputs. A removal makes room before an arrival.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelQ.delete();
      expWrite    = 1'b0;
      expAddr     = 0;
      expCode     = 0;
      expOverflow = 1'b0;
      expAddrErr  = 1'b0;
      frameTimer  = 0;
    end else begin
      expWrite = 1'b0;
      if (blank && modelQ.size() > 0) begin
        popped   = modelQ.pop_front();
        expWrite = 1'b1;
        expAddr  = popped.addr;
        expCode  = popped.code;
      end
      if (frameTimer > 0) begin
        frameTimer--;
        if (frameTimer == 0) begin
          if (frameAddr >= NUM_COLS) begin
            expAddrErr = 1'b1;
          end else if (modelQ.size() >= FIFO_DEPTH) begin
            expOverflow = 1'b1;
          end else begin
            modelQ.push_back('{addr: frameAddr, code: frameCode, cyc: 0});
          end
        end
      end
    end
  end

  // Compare every cycle away from the active edge and log observed writes
  always @(negedge clk) begin
    checkOutput("write", 32'(write), 32'(expWrite));
    checkOutput("address", 32'(address), 32'(expAddr));
    checkOutput("char_in", 32'(char_in), 32'(expCode));
    checkOutput("pending", 32'(pending), 32'(modelQ.size() > 0));
    checkOutput("overflow", 32'(overflow), 32'(expOverflow));
    checkOutput("addr_err", 32'(addr_err), 32'(expAddrErr));
    if (write === 1'b1) begin
      writeLog.push_back('{addr: int'(address), code: int'(char_in), cyc: cycleCount});
      if (latencyArmed) begin
        latency      = cycleCount - lastRiseCyc;
        latencyArmed = 1'b0;
      end
    end
  end

  // Send one frame MSB first; fewer than 10 bits aborts it. blankDelay > 0
  // raises blank that many clocks after the final rise is driven.
  task automatic applyStimulus(input int addr, input int code, input int nbits, input int blankDelay);
    logic [9:0] frame;
    frame = {addr[3:0], code[5:0]};
    @(negedge clk);
    scs_n = 1'b0;
    sclk  = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdata = frame[9-i];
      sclk  = 1'b0;
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      if (i == FRAME_W - 1) begin
        frameAddr   = addr;
        frameCode   = code;
        frameTimer  = 3;
        lastRiseCyc = cycleCount;
      end
      if (i == FRAME_W - 1 && blankDelay > 0) begin
        repeat (blankDelay) @(negedge clk);
        blank = 1'b1;
      end else begin
        repeat (2) @(negedge clk);
      end
    end
    sclk  = 1'b0;
    scs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    blank = 1'b0;
    sclk  = 1'b0;
    sdata = 1'b0;
    scs_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_write", 32'(write), 32'd0);
    checkOutput("reset_pending", 32'(pending), 32'd0);
    checkOutput("reset_flags", 32'({overflow, addr_err}), 32'd0);
    checkOutput("reset_addr_char", 32'({address, char_in}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    writeLog.delete();
  endtask

  initial begin
    #1;
    resetDut();

    $display("[TB] single frame with blank high");
    blank        = 1'b1;
    latencyArmed = 1'b1;
    applyStimulus(3, 'h2A, 10, 0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("single_count", 32'(writeLog.size()), 32'd1);
    if (writeLog.size() > 0) begin
      checkOutput("single_addr", 32'(writeLog[0].addr), 32'd3);
      checkOutput("single_char", 32'(writeLog[0].code), 32'h2A);
    end
    checkOutput("single_latency", 32'(latency), 32'd4);

    $display("[TB] fill while not blanked, then overflow and drain");
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i, 'h10 + i, 10, 0);
    end
    #1;
    checkOutput("fill_overflow", 32'(overflow), 32'd0);
    checkOutput("fill_pending", 32'(pending), 32'd1);
    applyStimulus(4, 'h14, 10, 0);
    #1;
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_no_writes", 32'(writeLog.size()), 32'd0);
    @(negedge clk);
    blank = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("drain_count", 32'(writeLog.size()), 32'd4);
    for (int i = 0; i < writeLog.size() && i < 4; i++) begin
      seen = writeLog[i];
      checkOutput("drain_addr", 32'(seen.addr), 32'(i));
      checkOutput("drain_char", 32'(seen.code), 32'('h10 + i));
      checkOutput("drain_consecutive", 32'(seen.cyc), 32'(writeLog[0].cyc + i));
    end
    checkOutput("drain_pending", 32'(pending), 32'd0);

    $display("[TB] out-of-range column");
    resetDut();
    blank = 1'b1;
    applyStimulus(15, 'h01, 10, 0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("range_addr_err", 32'(addr_err), 32'd1);
    checkOutput("range_pending", 32'(pending), 32'd0);
    checkOutput("range_no_writes", 32'(writeLog.size()), 32'd0);

    $display("[TB] aborted frame then valid frame");
    resetDut();
    blank = 1'b1;
    applyStimulus(2, 'h3F, 6, 0);
    applyStimulus(1, 'h05, 10, 0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("abort_count", 32'(writeLog.size()), 32'd1);
    if (writeLog.size() > 0) begin
      checkOutput("abort_addr", 32'(writeLog[0].addr), 32'd1);
      checkOutput("abort_char", 32'(writeLog[0].code), 32'h05);
    end
    checkOutput("abort_flags", 32'({overflow, addr_err}), 32'd0);

    $display("[TB] push into full FIFO on the same cycle as a pop");
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4 + i, 'h20 + i, 10, 0);
    end
    applyStimulus(8, 'h24, 10, 2);
    repeat (8) @(negedge clk);
    #1;
    checkOutput("simul_overflow", 32'(overflow), 32'd0);
    checkOutput("simul_count", 32'(writeLog.size()), 32'd5);
    for (int i = 0; i < writeLog.size() && i < 5; i++) begin
      seen = writeLog[i];
      checkOutput("simul_addr", 32'(seen.addr), 32'(4 + i));
      checkOutput("simul_char", 32'(seen.code), 32'('h20 + i));
    end

    $display("[TB] reset during drain");
    resetDut();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(9 + i, 'h30 + i, 10, 0);
    end
    @(negedge clk);
    blank = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("drain_started", 32'(write), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_write", 32'(write), 32'd0);
    checkOutput("async_addr_char", 32'({address, char_in}), 32'd0);
    checkOutput("async_pending", 32'(pending), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    writeLog.delete();
    repeat (10) @(negedge clk);
    #1;
    checkOutput("post_reset_no_writes", 32'(writeLog.size()), 32'd0);
    applyStimulus(12, 'h3C, 10, 0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("post_reset_count", 32'(writeLog.size()), 32'd1);
    if (writeLog.size() > 0) begin
      checkOutput("post_reset_addr", 32'(writeLog[0].addr), 32'd12);
      checkOutput("post_reset_char", 32'(writeLog[0].code), 32'h3C);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
